// File: rtl/mem_burst_arb_if.sv
// rtl/mem_burst_arb_if.sv - controller-side burst bus between mem_burst_arb and the DDR controller
//
// Parameters:
//   MEM_DATA_BITS  memory data width
//   ADDR_BITS      burst address width
//
// Signals:
//   mem_wr_burst_req/len/addr/data    arbiter -> controller, granted write burst
//   mem_wr_burst_data_req/finish      controller -> arbiter, write strobes
//   mem_rd_burst_req/len/addr         arbiter -> controller, granted read burst
//   mem_rd_burst_data_valid/data      controller -> arbiter, read data beats
//   mem_rd_burst_finish               controller -> arbiter, read completion
//
// Modports:
//   master  the arbiter side
//   slave   the controller side

interface mem_burst_arb_if #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 27
) ();
    logic                     mem_wr_burst_req;
    logic [9:0]               mem_wr_burst_len;
    logic [ADDR_BITS-1:0]     mem_wr_burst_addr;
    logic [MEM_DATA_BITS-1:0] mem_wr_burst_data;
    logic                     mem_wr_burst_data_req;
    logic                     mem_wr_burst_finish;

    logic                     mem_rd_burst_req;
    logic [9:0]               mem_rd_burst_len;
    logic [ADDR_BITS-1:0]     mem_rd_burst_addr;
    logic                     mem_rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] mem_rd_burst_data;
    logic                     mem_rd_burst_finish;

    modport master (
        output mem_wr_burst_req,
        output mem_wr_burst_len,
        output mem_wr_burst_addr,
        output mem_wr_burst_data,
        input  mem_wr_burst_data_req,
        input  mem_wr_burst_finish,
        output mem_rd_burst_req,
        output mem_rd_burst_len,
        output mem_rd_burst_addr,
        input  mem_rd_burst_data_valid,
        input  mem_rd_burst_data,
        input  mem_rd_burst_finish
    );

    modport slave (
        input  mem_wr_burst_req,
        input  mem_wr_burst_len,
        input  mem_wr_burst_addr,
        input  mem_wr_burst_data,
        output mem_wr_burst_data_req,
        output mem_wr_burst_finish,
        input  mem_rd_burst_req,
        input  mem_rd_burst_len,
        input  mem_rd_burst_addr,
        output mem_rd_burst_data_valid,
        output mem_rd_burst_data,
        output mem_rd_burst_finish
    );
endinterface

// File: rtl/mem_burst_arb.sv
// rtl/mem_burst_arb.sv - round-robin arbiter sharing one burst memory port among video channels
//
// Each of NUM_CH channels contributes a write requester (slot 2k) and a read
// requester (slot 2k+1). One burst is granted at a time; the winner's length
// and address are registered toward the controller, the winner's write data is
// muxed through, and controller strobes are routed back to the winner only.
//
// Ports:
//   mem_clk, rst                 clock and synchronous active-high reset
//   wr_burst_req/len/addr/data   per-channel write requesters (packed)
//   wr_burst_data_req/finish     per-channel write strobes, granted writer only
//   rd_burst_req/len/addr        per-channel read requesters (packed)
//   rd_burst_data_valid/finish   per-channel read strobes, granted reader only
//   rd_burst_data                read data broadcast to all readers
//   mem                          controller bus (mem_burst_arb_if.master)
//   arb_busy                     a grant is outstanding
//   arb_grant                    current or last granted slot
//
// Build option:
//   MEM_BURST_ARB_RD_PRIO_EN     when defined, pending reads beat all writes;
//                                round-robin order applies within each class.

module mem_burst_arb #(
    parameter int  NUM_CH        = 2,
    parameter int  MEM_DATA_BITS = 64,
    parameter int  ADDR_BITS     = 27,
    localparam int NUM_SLOTS     = 2 * NUM_CH,
    localparam int SLOT_BITS     = $clog2(NUM_SLOTS)
) (
    input  logic                            mem_clk,
    input  logic                            rst,

    input  logic [NUM_CH-1:0]               wr_burst_req,
    input  logic [NUM_CH*10-1:0]            wr_burst_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]     wr_burst_addr,
    input  logic [NUM_CH*MEM_DATA_BITS-1:0] wr_burst_data,
    output logic [NUM_CH-1:0]               wr_burst_data_req,
    output logic [NUM_CH-1:0]               wr_burst_finish,

    input  logic [NUM_CH-1:0]               rd_burst_req,
    input  logic [NUM_CH*10-1:0]            rd_burst_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]     rd_burst_addr,
    output logic [NUM_CH-1:0]               rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]        rd_burst_data,
    output logic [NUM_CH-1:0]               rd_burst_finish,

    mem_burst_arb_if.master                 mem,

    output logic                            arb_busy,
    output logic [SLOT_BITS-1:0]            arb_grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state, state_next;
    logic [SLOT_BITS-1:0]     grant_next;
    logic [SLOT_BITS-1:0]     rr_ptr, rr_ptr_next;
    logic [9:0]               len_q, len_next;
    logic [ADDR_BITS-1:0]     addr_q, addr_next;
    logic                     wr_req_q, wr_req_next;
    logic                     rd_req_q, rd_req_next;

    logic [NUM_SLOTS-1:0]     req_vec;
    logic [SLOT_BITS-1:0]     pick_slot;
    logic [9:0]               pick_len;
    logic [ADDR_BITS-1:0]     pick_addr;
    logic                     finish_hit;
    logic [MEM_DATA_BITS-1:0] wr_data_mux;

    // First set bit of reqs at or after ptr, wrapping modulo NUM_SLOTS.
    function automatic logic [SLOT_BITS-1:0] rr_pick(
        input logic [NUM_SLOTS-1:0] reqs,
        input logic [SLOT_BITS-1:0] ptr
    );
        logic [SLOT_BITS-1:0] sel;
        logic [SLOT_BITS-1:0] idx;
        logic                 found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = SLOT_BITS'((int'(ptr) + i) % NUM_SLOTS);
            if (!found && reqs[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Slot map plus per-requester strobe routing. Strobes are gated by BUSY
    // so a stray controller strobe while idle never reaches any channel.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign req_vec[2*k]   = wr_burst_req[k];
        assign req_vec[2*k+1] = rd_burst_req[k];

        assign wr_burst_data_req[k]   = arb_busy && (arb_grant == SLOT_BITS'(2*k))
                                        && mem.mem_wr_burst_data_req;
        assign wr_burst_finish[k]     = arb_busy && (arb_grant == SLOT_BITS'(2*k))
                                        && mem.mem_wr_burst_finish;
        assign rd_burst_data_valid[k] = arb_busy && (arb_grant == SLOT_BITS'(2*k+1))
                                        && mem.mem_rd_burst_data_valid;
        assign rd_burst_finish[k]     = arb_busy && (arb_grant == SLOT_BITS'(2*k+1))
                                        && mem.mem_rd_burst_finish;
    end

`ifdef MEM_BURST_ARB_RD_PRIO_EN
    logic [NUM_SLOTS-1:0] rd_reqs;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_rd_mask
        assign rd_reqs[2*k]   = 1'b0;
        assign rd_reqs[2*k+1] = rd_burst_req[k];
    end

    // Display reads must not underflow: any pending read is served first.
    assign pick_slot = (|rd_reqs) ? rr_pick(rd_reqs, rr_ptr) : rr_pick(req_vec, rr_ptr);
`else
    assign pick_slot = rr_pick(req_vec, rr_ptr);
`endif

    always_comb begin
        pick_len  = '0;
        pick_addr = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick_slot == SLOT_BITS'(2*k)) begin
                pick_len  = wr_burst_len[k*10 +: 10];
                pick_addr = wr_burst_addr[k*ADDR_BITS +: ADDR_BITS];
            end else if (pick_slot == SLOT_BITS'(2*k+1)) begin
                pick_len  = rd_burst_len[k*10 +: 10];
                pick_addr = rd_burst_addr[k*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Write data follows the grant combinationally; zero when a read holds it.
    always_comb begin
        wr_data_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_grant == SLOT_BITS'(2*k)) begin
                wr_data_mux = wr_burst_data[k*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
        end
    end

    // Only the finish matching the granted direction ends the burst.
    assign finish_hit = arb_grant[0] ? mem.mem_rd_burst_finish : mem.mem_wr_burst_finish;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state     <= IDLE;
            arb_grant <= '0;
            rr_ptr    <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
        end else begin
            state     <= state_next;
            arb_grant <= grant_next;
            rr_ptr    <= rr_ptr_next;
            len_q     <= len_next;
            addr_q    <= addr_next;
            wr_req_q  <= wr_req_next;
            rd_req_q  <= rd_req_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = arb_grant;
        rr_ptr_next = rr_ptr;
        len_next    = len_q;
        addr_next   = addr_q;
        wr_req_next = wr_req_q;
        rd_req_next = rd_req_q;

        case (state)
            IDLE: begin
                if (|req_vec) begin
                    grant_next  = pick_slot;
                    len_next    = pick_len;
                    addr_next   = pick_addr;
                    wr_req_next = ~pick_slot[0];
                    rd_req_next = pick_slot[0];
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                // Returning through IDLE for one cycle gives the finished
                // requester time to drop its held request before re-arbitration.
                if (finish_hit) begin
                    wr_req_next = 1'b0;
                    rd_req_next = 1'b0;
                    rr_ptr_next = (arb_grant == SLOT_BITS'(NUM_SLOTS-1))
                                  ? '0 : arb_grant + SLOT_BITS'(1);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign arb_busy              = (state == BUSY);
    assign rd_burst_data         = mem.mem_rd_burst_data;

    assign mem.mem_wr_burst_req  = wr_req_q;
    assign mem.mem_wr_burst_len  = len_q;
    assign mem.mem_wr_burst_addr = addr_q;
    assign mem.mem_wr_burst_data = wr_data_mux;
    assign mem.mem_rd_burst_req  = rd_req_q;
    assign mem.mem_rd_burst_len  = len_q;
    assign mem.mem_rd_burst_addr = addr_q;

endmodule
